line_buffer_reader: RTL and testbench

//  Read side of the median-filter line buffer. The write side fills one line of WIDTH pixels.

---
 rtl/line_buffer_reader.sv | 252 +++++++++++++++++++++++++
 tb/tb_line_buffer_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_reader.sv
// line_buffer_reader
//   Read side of the median-filter line buffer. Once the writer signals that a line
//   of WIDTH pixels is complete, this block reads the line back from the BRAM
//   (1-cycle read latency) and streams it downstream over valid/ready. It tracks
//   column and row position, acknowledges each delivered line so the writer can
//   reuse it, and flags the end of a frame after HEIGHT lines.
//
//   Optional feature macro: FRAME_MARKERS_EN adds m_sof/m_eof frame markers.
//
// Ports
//   clk         single clock, all logic on posedge
//   rst         synchronous reset, active-high
//   line_ready  1-cycle pulse: a complete line is waiting in the buffer
//   line_ack    1-cycle pulse: current line fully delivered, buffer line reusable
//   rd_en       BRAM read enable
//   rd_addr     BRAM read address (column index)
//   rd_data     BRAM read data, valid the cycle after rd_en
//   m_valid     output pixel valid
//   m_ready     downstream ready
//   m_data      output pixel
//   m_last      last pixel of the line
//   frame_done  1-cycle pulse with the line_ack of the last row
//   busy        reader is not idle
//   ovf         sticky: a line_ready pulse was lost, cleared only by rst
//   m_sof       (FRAME_MARKERS_EN) first pixel of the frame
//   m_eof       (FRAME_MARKERS_EN) last pixel of the frame
module line_buffer_reader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_ready,
  output logic              line_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_done,
  output logic              busy,
  output logic              ovf
`ifdef FRAME_MARKERS_EN
  ,
  output logic              m_sof,
  output logic              m_eof
`endif
);

  localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);

  // Tag bits travel through the FIFO alongside each pixel: {eof, sof, last}
  // with frame markers, just {last} without.
`ifdef FRAME_MARKERS_EN
  localparam int TAG_W = 3;
`else
  localparam int TAG_W = 1;
`endif
  localparam int ENT_W = DATA_W + TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  col;
  logic [ROW_W-1:0]   row;
  logic               pending;
  logic               inflight;
  logic [TAG_W-1:0]   inflight_tag;
  logic [TAG_W-1:0]   issue_tag;
  logic [1:0]         fifo_count;
  logic [ENT_W-1:0]   head_ent;
  logic [ENT_W-1:0]   tail_ent;
  logic [ENT_W-1:0]   push_ent;
  logic               push;
  logic               pop;
  logic               issue;
  logic               col_at_last;
  logic               hs_last;
  logic               line_done;
  logic               consume;
  logic               take_req;
  logic [2:0]         outstanding;

  assign col_at_last = (col == COL_LAST);
  assign m_valid     = (fifo_count != 2'd0);
  assign pop         = m_valid && m_ready;
  assign push        = inflight;
  assign hs_last     = pop && m_last;
  assign line_done   = (state == DRAIN) && hs_last;
  assign busy        = (state != IDLE);

  // At most two pixels may be buffered or in flight. A pop in the same cycle
  // frees a slot, which is what lets the reader sustain one pixel per clock.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue       = (state == READ) && ((outstanding < 3'd2) || pop);
  assign rd_en       = issue;
  assign rd_addr     = col;

  // A queued request is used up either when the reader is idle or when the
  // current line finishes; a new request is queued whenever the reader cannot
  // start it directly.
  assign consume  = pending && ((state == IDLE) || line_done);
  assign take_req = line_ready && (busy || pending);

`ifdef FRAME_MARKERS_EN
  assign issue_tag = {(row == ROW_LAST) && col_at_last,
                      (row == '0) && (col == '0),
                      col_at_last};
  assign m_sof     = head_ent[DATA_W+1];
  assign m_eof     = head_ent[DATA_W+2];
`else
  assign issue_tag = col_at_last;
`endif

  assign push_ent = {inflight_tag, rd_data};
  assign m_data   = head_ent[DATA_W-1:0];
  assign m_last   = head_ent[DATA_W];

  // State register for the read sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start on a request, leave READ after the last column
  // has been issued, and leave DRAIN once the last pixel is handed off.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (line_ready || pending) begin
          state_next = READ;
        end
      end
      READ: begin
        if (issue && col_at_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (hs_last) begin
          state_next = pending ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Column counter and the one-deep record of the read currently in flight,
  // so the returning data can be tagged and pushed into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight     <= issue;
      inflight_tag <= issue_tag;
      if (issue) begin
        col <= col_at_last ? '0 : col + 1'b1;
      end
    end
  end

  // Line completion: acknowledge the line, advance the row and flag the end
  // of the frame when the last row is acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_ack   <= 1'b0;
      frame_done <= 1'b0;
      row        <= '0;
    end else begin
      line_ack   <= line_done;
      frame_done <= line_done && (row == ROW_LAST);
      if (line_done) begin
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end
    end
  end

  // Request bookkeeping: one request can wait behind the active line; a
  // further request with no free slot is dropped and recorded in ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else if (take_req) begin
      if (!pending || consume) begin
        pending <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (consume) begin
      pending <= 1'b0;
    end
  end

  // Two-entry output FIFO with the head held in a register so m_data/m_last
  // come straight from flops and stay put while the consumer stalls. The
  // issue rule guarantees a push into a full FIFO only happens with a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= 2'd0;
      head_ent   <= '0;
      tail_ent   <= '0;
    end else begin
      case (fifo_count)
        2'd0: begin
          if (push) begin
            head_ent   <= push_ent;
            fifo_count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_ent <= push_ent;
          end else if (push) begin
            tail_ent   <= push_ent;
            fifo_count <= 2'd2;
          end else if (pop) begin
            fifo_count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_ent <= tail_ent;
            if (push) begin
              tail_ent <= push_ent;
            end else begin
              fifo_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_reader.sv
// tb_line_buffer_reader
//   Testbench for line_buffer_reader with WIDTH=4, HEIGHT=2, DATA_W=8 and a
//   BRAM model returning 8'h10 + addr one cycle after each read.
module tb_line_buffer_reader;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_ready;
  logic              line_ack;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              frame_done;
  logic              busy;
  logic              ovf;
`ifdef FRAME_MARKERS_EN
  logic              m_sof;
  logic              m_eof;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       sof;
    logic       eof;
  } pix_t;

  typedef struct {
    logic       lr;
    logic       mr;
    logic       e_rd_en;
    logic [1:0] e_addr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_ack;
    logic       e_busy;
    logic       e_fd;
  } vec_t;

  pix_t sb[$];
  vec_t vq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   ack_cnt = 0;
  int   fd_cnt = 0;
  int   issued_cnt = 0;
  int   delivered_cnt = 0;
  int   tb_row = 0;

  line_buffer_reader #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_ready(line_ready),
    .line_ack  (line_ack),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_done(frame_done),
    .busy      (busy),
    .ovf       (ovf)
`ifdef FRAME_MARKERS_EN
    ,
    .m_sof     (m_sof),
    .m_eof     (m_eof)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // BRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 8'h10 + {6'd0, rd_addr};
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
  endtask

  // Queue the four pixels of one accepted line, tagged with the frame markers
  // that the line's row should produce.
  task automatic pushLine();
    for (int c = 0; c < WIDTH; c++) begin
      pix_t p;
      p.data = 8'h10 + 8'(c);
      p.last = (c == WIDTH - 1);
      p.sof  = (tb_row == 0) && (c == 0);
      p.eof  = (tb_row == HEIGHT - 1) && (c == WIDTH - 1);
      sb.push_back(p);
    end
    tb_row = (tb_row + 1) % HEIGHT;
  endtask

  task automatic applyStimulus(input logic lr, input logic mr, input logic accept);
    line_ready = lr;
    m_ready    = mr;
    if (lr && accept) pushLine();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input int budget);
    logic seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      if (line_ack) seen = 1'b1;
      else nextCycle();
    end
    checkOutput("ack_wait", {31'd0, seen}, 32'd1);
  endtask

  // Monitor at the falling edge: scoreboard every handshake and count
  // read issues, acknowledgements and frame ends.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) issued_cnt++;
      if (line_ack) ack_cnt++;
      if (frame_done) fd_cnt++;
      if (m_valid && m_ready) begin
        delivered_cnt++;
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_pixel", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          pix_t e;
          e = sb.pop_front();
          checkOutput("sb_data", {24'd0, m_data}, {24'd0, e.data});
          checkOutput("sb_last", {31'd0, m_last}, {31'd0, e.last});
`ifdef FRAME_MARKERS_EN
          checkOutput("sb_sof", {31'd0, m_sof}, {31'd0, e.sof});
          checkOutput("sb_eof", {31'd0, m_eof}, {31'd0, e.eof});
`endif
        end
      end
    end
  end

  task automatic addLine(input logic fd);
    vq.push_back('{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, fd});
    vq.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    int ack0;
    int del0;
    rst        = 1'b1;
    line_ready = 1'b0;
    m_ready    = 1'b1;
    addLine(1'b0);
    addLine(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_line_ack", {31'd0, line_ack}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, rd_en}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_m_data", {24'd0, m_data}, 32'd0);
    checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);

    $display("[TB] two lines, cycle-exact table");
    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].lr, vq[i].mr, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d_rd_en", i), {31'd0, rd_en}, {31'd0, vq[i].e_rd_en});
      if (vq[i].e_rd_en)
        checkOutput($sformatf("vec%0d_rd_addr", i), {30'd0, rd_addr}, {30'd0, vq[i].e_addr});
      checkOutput($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vq[i].e_valid});
      if (vq[i].e_valid) begin
        checkOutput($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vq[i].e_data});
        checkOutput($sformatf("vec%0d_m_last", i), {31'd0, m_last}, {31'd0, vq[i].e_last});
      end
      checkOutput($sformatf("vec%0d_line_ack", i), {31'd0, line_ack}, {31'd0, vq[i].e_ack});
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].e_busy});
      checkOutput($sformatf("vec%0d_frame_done", i), {31'd0, frame_done}, {31'd0, vq[i].e_fd});
      nextCycle();
    end

    $display("[TB] downstream stall");
    del0 = delivered_cnt;
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(c == 0, (c < 3), 1'b1);
      #1;
      if (c >= 3) begin
        checkOutput($sformatf("stall_c%0d_valid", c), {31'd0, m_valid}, 32'd1);
        checkOutput($sformatf("stall_c%0d_data", c), {24'd0, m_data}, 32'h10);
        checkOutput($sformatf("stall_c%0d_outstanding", c),
                    {31'd0, (issued_cnt - delivered_cnt) <= 2}, 32'd1);
      end
      if (c >= 4) checkOutput($sformatf("stall_c%0d_rd_en", c), {31'd0, rd_en}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitAck(30);
    nextCycle();
    checkOutput("stall_delivered", delivered_cnt - del0, 32'd4);
    checkOutput("stall_sb_empty", sb.size(), 32'd0);

    $display("[TB] queued second line");
    ack0 = ack_cnt;
    for (int c = 0; c <= 7; c++) begin
      applyStimulus((c == 0) || (c == 4), 1'b1, 1'b1);
      #1;
      if (c == 7) begin
        checkOutput("pend_line_ack", {31'd0, line_ack}, 32'd1);
        checkOutput("pend_rd_en", {31'd0, rd_en}, 32'd1);
        checkOutput("pend_rd_addr", {30'd0, rd_addr}, 32'd0);
        checkOutput("pend_ovf", {31'd0, ovf}, 32'd0);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitAck(30);
    nextCycle();
    nextCycle();
    checkOutput("pend_acks", ack_cnt - ack0, 32'd2);
    checkOutput("pend_sb_empty", sb.size(), 32'd0);

    $display("[TB] overflow");
    checkOutput("ovf_before", {31'd0, ovf}, 32'd0);
    ack0 = ack_cnt;
    del0 = delivered_cnt;
    for (int c = 0; c <= 4; c++) begin
      applyStimulus((c == 0) || (c >= 2), 1'b1, (c <= 2));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
    waitAck(30);
    nextCycle();
    waitAck(30);
    repeat (10) nextCycle();
    checkOutput("ovf_acks", ack_cnt - ack0, 32'd2);
    checkOutput("ovf_delivered", delivered_cnt - del0, 32'd8);
    checkOutput("ovf_sb_empty", sb.size(), 32'd0);
    checkOutput("ovf_sticky", {31'd0, ovf}, 32'd1);
    checkOutput("ovf_idle", {31'd0, busy}, 32'd0);

    $display("[TB] reset mid-line");
    ack0 = ack_cnt;
    for (int c = 0; c <= 3; c++) begin
      applyStimulus(c == 0, 1'b1, 1'b1);
      nextCycle();
    end
    rst = 1'b1;
    sb.delete();
    tb_row = 0;
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("mid_rst_rd_en", {31'd0, rd_en}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("mid_rst_line_ack", {31'd0, line_ack}, 32'd0);
    checkOutput("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    repeat (5) nextCycle();
    checkOutput("mid_rst_no_ack", ack_cnt - ack0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("restart_rd_en", {31'd0, rd_en}, 32'd1);
    checkOutput("restart_rd_addr", {30'd0, rd_addr}, 32'd0);
    waitAck(30);
    checkOutput("restart_no_frame_done", {31'd0, frame_done}, 32'd0);
    nextCycle();
    ack0 = fd_cnt;
    applyStimulus(1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitAck(30);
    checkOutput("restart_frame_done", {31'd0, frame_done}, 32'd1);
    nextCycle();
    checkOutput("restart_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
